// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the core load/store
// path and a host/loader port, sequencing each access as grant, access window, ack.
module dmem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter bit          HOST_PRIO   = 1'b0,
  parameter logic [4:0]  HOST_MEMI   = 5'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [4:0]  c_memi,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        h_req,
  input  logic        h_we,
  input  logic [31:0] h_addr,
  input  logic [31:0] h_wdata,
  output logic        h_ack,
  output logic [31:0] h_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [4:0]  m_memi,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        grant_host
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rr_host_q, rr_host_d;
  logic        we_q, we_d;
  logic        pick_host;

  logic        m_en_d, m_we_d, c_ack_d, h_ack_d, grant_host_d;
  logic [4:0]  m_memi_d;
  logic [31:0] m_addr_d, m_wdata_d, c_rdata_d, h_rdata_d;

  assign c_stall = c_req & ~c_ack;

  // All outputs are registered, so the next-state logic also computes their next values;
  // m_we is raised one cycle early so the strobe lands exactly on the last access cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_host_d    = rr_host_q;
    we_d         = we_q;
    pick_host    = 1'b0;
    m_en_d       = m_en;
    m_we_d       = 1'b0;
    m_memi_d     = m_memi;
    m_addr_d     = m_addr;
    m_wdata_d    = m_wdata;
    c_ack_d      = 1'b0;
    h_ack_d      = 1'b0;
    c_rdata_d    = c_rdata;
    h_rdata_d    = h_rdata;
    grant_host_d = grant_host;

    case (state_q)
      IDLE: begin
        grant_host_d = 1'b0;
        m_en_d       = 1'b0;
        if (c_req || h_req) begin
          pick_host    = h_req & (~c_req | HOST_PRIO | ~rr_host_q);
          state_d      = ACCESS;
          cnt_d        = CNT_LOAD;
          rr_host_d    = pick_host;
          grant_host_d = pick_host;
          m_en_d       = 1'b1;
          if (pick_host) begin
            we_d      = h_we;
            m_memi_d  = HOST_MEMI;
            m_addr_d  = h_addr;
            m_wdata_d = h_wdata;
          end else begin
            we_d      = c_we;
            m_memi_d  = c_memi;
            m_addr_d  = c_addr;
            m_wdata_d = c_wdata;
          end
          m_we_d = (CNT_LOAD == 4'd0) ? we_d : 1'b0;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          m_en_d  = 1'b0;
          if (!we_q) begin
            if (grant_host) h_rdata_d = m_rdata;
            else            c_rdata_d = m_rdata;
          end
          if (grant_host) h_ack_d = 1'b1;
          else            c_ack_d = 1'b1;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          m_we_d = (cnt_q == 4'd1) ? we_q : 1'b0;
        end
      end
      DONE: begin
        state_d      = IDLE;
        m_en_d       = 1'b0;
        grant_host_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_host_q  <= 1'b1;
      we_q       <= 1'b0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_memi     <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      c_ack      <= 1'b0;
      h_ack      <= 1'b0;
      c_rdata    <= '0;
      h_rdata    <= '0;
      grant_host <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_host_q  <= rr_host_d;
      we_q       <= we_d;
      m_en       <= m_en_d;
      m_we       <= m_we_d;
      m_memi     <= m_memi_d;
      m_addr     <= m_addr_d;
      m_wdata    <= m_wdata_d;
      c_ack      <= c_ack_d;
      h_ack      <= h_ack_d;
      c_rdata    <= c_rdata_d;
      h_rdata    <= h_rdata_d;
      grant_host <= grant_host_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance A (WAIT_CYCLES=1, round-robin) and instance B
// (WAIT_CYCLES=3, host priority), directed steps plus a randomized transaction model on A.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_c_req, a_c_we, a_c_ack, a_c_stall, a_h_req, a_h_we, a_h_ack;
  logic        a_m_en, a_m_we, a_grant_host;
  logic [4:0]  a_c_memi, a_m_memi;
  logic [31:0] a_c_addr, a_c_wdata, a_c_rdata, a_h_addr, a_h_wdata, a_h_rdata;
  logic [31:0] a_m_addr, a_m_wdata, a_m_rdata;

  logic        b_c_req, b_c_we, b_c_ack, b_c_stall, b_h_req, b_h_we, b_h_ack;
  logic        b_m_en, b_m_we, b_grant_host;
  logic [4:0]  b_c_memi, b_m_memi;
  logic [31:0] b_c_addr, b_c_wdata, b_c_rdata, b_h_addr, b_h_wdata, b_h_rdata;
  logic [31:0] b_m_addr, b_m_wdata, b_m_rdata;

  dmem_arbiter #(.WAIT_CYCLES(1), .HOST_PRIO(1'b0), .HOST_MEMI(5'd2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .c_req(a_c_req), .c_we(a_c_we), .c_memi(a_c_memi), .c_addr(a_c_addr), .c_wdata(a_c_wdata),
    .c_ack(a_c_ack), .c_rdata(a_c_rdata), .c_stall(a_c_stall),
    .h_req(a_h_req), .h_we(a_h_we), .h_addr(a_h_addr), .h_wdata(a_h_wdata),
    .h_ack(a_h_ack), .h_rdata(a_h_rdata),
    .m_en(a_m_en), .m_we(a_m_we), .m_memi(a_m_memi), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_rdata(a_m_rdata), .grant_host(a_grant_host));

  dmem_arbiter #(.WAIT_CYCLES(3), .HOST_PRIO(1'b1), .HOST_MEMI(5'd2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .c_req(b_c_req), .c_we(b_c_we), .c_memi(b_c_memi), .c_addr(b_c_addr), .c_wdata(b_c_wdata),
    .c_ack(b_c_ack), .c_rdata(b_c_rdata), .c_stall(b_c_stall),
    .h_req(b_h_req), .h_we(b_h_we), .h_addr(b_h_addr), .h_wdata(b_h_wdata),
    .h_ack(b_h_ack), .h_rdata(b_h_rdata),
    .m_en(b_m_en), .m_we(b_m_we), .m_memi(b_m_memi), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_rdata(b_m_rdata), .grant_host(b_grant_host));

  // Memory behind A: 16 words, preloadable from the bench, written by the arbiter's strobe.
  logic [31:0] mem_a [16];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [31:0] pre_data;
  always @(posedge clk) begin
    if (pre_we) mem_a[pre_idx] <= pre_data;
    else if (a_m_en && a_m_we) mem_a[a_m_addr[5:2]] <= a_m_wdata;
  end
  assign a_m_rdata = mem_a[a_m_addr[5:2]];

  // Memory behind B returns an address-derived pattern; write strobes are counted.
  assign b_m_rdata = b_m_addr ^ 32'h5A5A_0000;
  int b_we_cnt = 0;
  always @(posedge clk) if (b_m_we) b_we_cnt <= b_we_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference state for A
  logic [31:0] ref_mem [16];
  logic        rr_host;
  logic [31:0] exp_c_rdata, exp_h_rdata;
  logic        c_pend, h_pend, win_host, t_we;
  logic [31:0] t_addr, t_wdata;
  logic [4:0]  t_memi;
  int          saved_we;

  initial begin
    rst_n = 1'b1;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    {a_c_req, a_c_we, a_h_req, a_h_we} = '0;
    a_c_memi = '0; a_c_addr = '0; a_c_wdata = '0; a_h_addr = '0; a_h_wdata = '0;
    {b_c_req, b_c_we, b_h_req, b_h_we} = '0;
    b_c_memi = '0; b_c_addr = '0; b_c_wdata = '0; b_h_addr = '0; b_h_wdata = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("a_reset_outs", 32'(|{a_m_en, a_m_we, a_m_memi, a_m_addr, a_m_wdata, a_c_ack, a_h_ack,
                               a_c_rdata, a_h_rdata, a_grant_host}), 32'd0);
    chk("b_reset_outs", 32'(|{b_m_en, b_m_we, b_m_memi, b_m_addr, b_m_wdata, b_c_ack, b_h_ack,
                               b_c_rdata, b_h_rdata, b_grant_host}), 32'd0);
    for (int i = 0; i < 16; i++) begin
      pre_we = 1'b1; pre_idx = 4'(i);
      pre_data = (i == 4) ? 32'hDEAD_BEEF : $urandom;
      ref_mem[i] = pre_data;
      tick();
    end
    pre_we = 1'b0;
    rst_n = 1'b1;
    tick();

    // A: both requests held from reset -> core, host, core, host, acks 3 cycles apart
    a_c_req = 1'b1; a_c_addr = 32'h4; a_c_memi = 5'd0;
    a_h_req = 1'b1; a_h_addr = 32'h8;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_grant_host", a_grant_host, 32'(i % 2));
      chk("rr_m_addr", a_m_addr, (i % 2) ? 32'h8 : 32'h4);
      chk("rr_stall", a_c_stall, 32'd1);
      tick();
      chk("rr_c_ack", a_c_ack, 32'(1 - (i % 2)));
      chk("rr_h_ack", a_h_ack, 32'(i % 2));
      if (i % 2) chk("rr_h_rdata", a_h_rdata, ref_mem[2]);
      else       chk("rr_c_rdata", a_c_rdata, ref_mem[1]);
      if (i == 3) begin a_c_req = 1'b0; a_h_req = 1'b0; end
      tick();
      chk("rr_idle_grant", a_grant_host, 32'd0);
    end

    // A: core read of 0x10
    a_c_req = 1'b1; a_c_we = 1'b0; a_c_addr = 32'h10; a_c_memi = 5'd4;
    #1 chk("rd_stall_c0", a_c_stall, 32'd1);
    tick();
    chk("rd_m_en_c1", a_m_en, 32'd1);
    chk("rd_m_addr_c1", a_m_addr, 32'h10);
    chk("rd_m_memi_c1", a_m_memi, 32'd4);
    chk("rd_m_we_c1", a_m_we, 32'd0);
    chk("rd_stall_c1", a_c_stall, 32'd1);
    tick();
    chk("rd_ack_c2", a_c_ack, 32'd1);
    chk("rd_rdata_c2", a_c_rdata, 32'hDEAD_BEEF);
    chk("rd_stall_c2", a_c_stall, 32'd0);
    chk("rd_m_en_c2", a_m_en, 32'd0);
    a_c_req = 1'b0;
    tick();
    chk("rd_ack_c3", a_c_ack, 32'd0);

    // A: core write of 0x12345678 to 0x20
    a_c_req = 1'b1; a_c_we = 1'b1; a_c_addr = 32'h20; a_c_wdata = 32'h1234_5678; a_c_memi = 5'd1;
    tick();
    chk("wr_m_we", a_m_we, 32'd1);
    chk("wr_m_addr", a_m_addr, 32'h20);
    chk("wr_m_wdata", a_m_wdata, 32'h1234_5678);
    chk("wr_m_memi", a_m_memi, 32'd1);
    tick();
    chk("wr_m_we_done", a_m_we, 32'd0);
    chk("wr_ack", a_c_ack, 32'd1);
    chk("wr_rdata_kept", a_c_rdata, 32'hDEAD_BEEF);
    chk("wr_mem", mem_a[8], 32'h1234_5678);
    ref_mem[8] = 32'h1234_5678;
    a_c_req = 1'b0; a_c_we = 1'b0;
    tick();

    // B: host priority with both requests held continuously
    b_c_req = 1'b1; b_c_addr = 32'h100;
    b_h_req = 1'b1; b_h_addr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("hp_grant_host", b_grant_host, 32'd1);
        chk("hp_m_memi", b_m_memi, 32'd2);
        chk("hp_m_addr", b_m_addr, 32'h200);
        chk("hp_c_stall", b_c_stall, 32'd1);
      end
      tick();
      chk("hp_h_ack", b_h_ack, 32'd1);
      chk("hp_c_ack", b_c_ack, 32'd0);
      chk("hp_h_rdata", b_h_rdata, 32'h200 ^ 32'h5A5A_0000);
      chk("hp_c_stall_done", b_c_stall, 32'd1);
      if (i == 2) begin b_c_req = 1'b0; b_h_req = 1'b0; end
      tick();
    end

    // B: host read, address changed during the access window
    b_h_req = 1'b1; b_h_we = 1'b0; b_h_addr = 32'h40;
    tick();
    chk("ha_m_addr_1", b_m_addr, 32'h40);
    b_h_addr = 32'h80;
    for (int k = 2; k <= 3; k++) begin
      tick();
      chk("ha_m_addr_held", b_m_addr, 32'h40);
      chk("ha_m_en", b_m_en, 32'd1);
      chk("ha_h_ack_early", b_h_ack, 32'd0);
    end
    tick();
    chk("ha_h_ack_c4", b_h_ack, 32'd1);
    chk("ha_h_rdata", b_h_rdata, 32'h40 ^ 32'h5A5A_0000);
    b_h_req = 1'b0;
    tick();

    // B: reset in the second access cycle of a core write
    saved_we = b_we_cnt;
    b_c_req = 1'b1; b_c_we = 1'b1; b_c_addr = 32'h30; b_c_wdata = 32'hCAFE_F00D; b_c_memi = 5'd2;
    tick();
    chk("rs_m_we_a1", b_m_we, 32'd0);
    tick();
    chk("rs_m_we_a2", b_m_we, 32'd0);
    rst_n = 1'b0; b_c_req = 1'b0; b_c_we = 1'b0;
    #1;
    chk("rs_outs_zero", 32'(|{b_m_en, b_m_we, b_m_memi, b_m_addr, b_m_wdata, b_c_ack, b_h_ack,
                               b_c_rdata, b_h_rdata, b_grant_host, b_c_stall}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rs_no_ack", 32'(b_c_ack | b_h_ack), 32'd0);
      chk("rs_no_en", b_m_en, 32'd0);
    end
    chk("rs_no_strobe", 32'(b_we_cnt), 32'(saved_we));
    b_c_req = 1'b1; b_c_addr = 32'h44;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("rs_new_m_en", b_m_en, 32'd1);
    end
    tick();
    chk("rs_new_ack", b_c_ack, 32'd1);
    chk("rs_new_rdata", b_c_rdata, 32'h44 ^ 32'h5A5A_0000);
    b_c_req = 1'b0;
    tick();

    // A: randomized traffic against the transaction-level model (A was reset above)
    rr_host = 1'b1; exp_c_rdata = '0; exp_h_rdata = '0;
    c_pend = 1'b0; h_pend = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!c_pend && ($urandom_range(0, 2) != 0)) begin
        c_pend = 1'b1; a_c_req = 1'b1; a_c_we = 1'($urandom);
        a_c_addr = {26'd0, 4'($urandom), 2'd0}; a_c_wdata = $urandom; a_c_memi = 5'($urandom);
      end
      if (!h_pend && ($urandom_range(0, 2) != 0)) begin
        h_pend = 1'b1; a_h_req = 1'b1; a_h_we = 1'($urandom);
        a_h_addr = {26'd0, 4'($urandom), 2'd0}; a_h_wdata = $urandom;
      end
      if (!c_pend && !h_pend) begin
        chk("rnd_idle_en", a_m_en, 32'd0);
        tick();
        continue;
      end
      win_host = (c_pend && h_pend) ? !rr_host : h_pend;
      rr_host = win_host;
      t_we    = win_host ? a_h_we    : a_c_we;
      t_addr  = win_host ? a_h_addr  : a_c_addr;
      t_wdata = win_host ? a_h_wdata : a_c_wdata;
      t_memi  = win_host ? 5'd2      : a_c_memi;
      tick();
      chk("rnd_grant_host", a_grant_host, 32'(win_host));
      chk("rnd_m_en", a_m_en, 32'd1);
      chk("rnd_m_addr", a_m_addr, t_addr);
      chk("rnd_m_memi", a_m_memi, 32'(t_memi));
      chk("rnd_m_we", a_m_we, 32'(t_we));
      if (t_we) chk("rnd_m_wdata", a_m_wdata, t_wdata);
      chk("rnd_c_stall", a_c_stall, 32'(c_pend));
      if (t_we) ref_mem[t_addr[5:2]] = t_wdata;
      else if (win_host) exp_h_rdata = ref_mem[t_addr[5:2]];
      else exp_c_rdata = ref_mem[t_addr[5:2]];
      tick();
      chk("rnd_c_ack", a_c_ack, 32'(!win_host));
      chk("rnd_h_ack", a_h_ack, 32'(win_host));
      chk("rnd_c_rdata", a_c_rdata, exp_c_rdata);
      chk("rnd_h_rdata", a_h_rdata, exp_h_rdata);
      chk("rnd_done_we", a_m_we, 32'd0);
      chk("rnd_done_stall", a_c_stall, 32'(c_pend && win_host));
      if (win_host) begin h_pend = 1'b0; a_h_req = 1'b0; end
      else          begin c_pend = 1'b0; a_c_req = 1'b0; end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the RISC-V core load/store path and a host/loader port (program load, debug peek/poke).
- Sequences each access through a multi-cycle memory timing window: grant, WAIT_CYCLES access cycles, then a one-cycle acknowledge.
- Generates the core stall used to gate PC enable while a core access is pending.
- Sits between the core's ALU-address/RF-data outputs and the data memory instance.

Parameters:
- WAIT_CYCLES, 1, memory access cycles per transaction (legal 1..15).
- HOST_PRIO, 0, 0 = round-robin on ties; 1 = host always wins ties.
- HOST_MEMI, 5'd2, memi code driven to memory for host accesses (full word).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- c_req  in  1  core request, held until c_ack
- c_we  in  1  core write enable
- c_memi  in  5  core access size/sign code, passed to memory
- c_addr  in  32  core address (ALU output)
- c_wdata  in  32  core store data (RF port B)
- c_ack  out  1  core transaction done, one-cycle pulse
- c_rdata  out  32  core load data, valid while c_ack=1
- c_stall  out  1  core stall: c_req & ~c_ack (combinational)
- h_req  in  1  host request, held until h_ack
- h_we  in  1  host write enable
- h_addr  in  32  host address
- h_wdata  in  32  host write data
- h_ack  out  1  host transaction done, one-cycle pulse
- h_rdata  out  32  host read data, valid while h_ack=1
- m_en  out  1  memory access window active
- m_we  out  1  memory write strobe
- m_memi  out  5  memory size code
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data
- grant_host  out  1  1 while the current transaction belongs to host

Behaviour:
- Reset (async, rst_n=0) forces all registered outputs to 0 (m_en, m_we, m_memi, m_addr, m_wdata, c_ack, h_ack, c_rdata, h_rdata, grant_host) and sets state=IDLE, rr_last=host, wait counter=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples c_req and h_req.
  - If neither is set, stay in IDLE.
  - Single requester: grant it.
  - Both requesting, HOST_PRIO=0: grant the one not in rr_last.
  - Both requesting, HOST_PRIO=1: grant host.
  - On grant: latch we/memi/addr/wdata of the winner (host memi = HOST_MEMI), set grant_host, load counter=WAIT_CYCLES-1, update rr_last, go to ACCESS.
- ACCESS:
  - m_en=1. m_addr, m_wdata and m_memi come from the latched values; requester input changes are ignored.
  - Counter decrements each cycle.
  - On the cycle with counter=0 (last ACCESS cycle): m_we equals the latched we (exactly one write strobe per write), m_rdata is captured into the winner's rdata register, and the next state is DONE.
- DONE: m_en=0, m_we=0; winner's ack=1 for exactly this cycle with rdata valid; next state IDLE.
- Latency: request sampled in IDLE cycle N; ACCESS occupies N+1..N+WAIT_CYCLES; ack at N+WAIT_CYCLES+1. Back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles.
- Handshake:
  - req must stay high until ack is observed and must be low in the cycle after ack.
  - req high in any later IDLE cycle is a new transaction.
  - Dropping req before ack is illegal and is not checked; the transaction still completes and acks.
- The loser of a tie keeps its req high and is granted on the next IDLE. With HOST_PRIO=0 it is guaranteed service within one transaction.
- rdata registers hold their value until the next read by the same requester; writes leave rdata unchanged.
- c_stall is combinational and stays high from the cycle c_req rises through the last ACCESS cycle; it is low in the ack cycle.
- Reset mid-ACCESS: the transaction is aborted, no ack is issued, and m_we is low immediately. A write whose strobe already occurred is not undone.
- grant_host is valid through ACCESS and DONE and cleared in IDLE.

Test Plan:
- Core read, WAIT_CYCLES=1: c_req=1, c_addr=0x10 at cycle 0, m_rdata=0xDEADBEEF -> m_en=1 and m_addr=0x10 at cycle 1; c_ack=1 with c_rdata=0xDEADBEEF at cycle 2; c_stall high cycles 0-1, low at cycle 2.
- Core write c_addr=0x20, c_wdata=0x12345678, c_memi=5'd1 -> m_we high exactly one cycle with m_addr=0x20, m_wdata=0x12345678, m_memi=1; c_rdata unchanged.
- Both requests held after reset, HOST_PRIO=0 -> grant order core, host, core, host; grant_host 0,1,0,1; each ack spaced 3 cycles apart with WAIT_CYCLES=1.
- HOST_PRIO=1, both continuously requesting -> host granted every transaction, m_memi=HOST_MEMI=2, c_stall stays high.
- WAIT_CYCLES=3, host read with h_addr changed during ACCESS -> m_addr holds the original address for 3 cycles; h_ack at cycle 4.
- rst_n low in the second ACCESS cycle of a write with WAIT_CYCLES=3 -> all outputs 0 immediately, no m_we pulse, no ack; FSM in IDLE on release.
